// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OP    = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } booth_state_e;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_e;

  // Radix-2 Booth recoding of the {Q0, q_prev} pair.
  function automatic booth_op_e booth_op(input logic [1:0] bits);
    booth_op_e op;
    case (bits)
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_datapath.sv
// M/A/Q/q_prev register file with N-bit add/sub and arithmetic right shift,
// sequenced by load/op/shift strobes from the controlling FSM.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  booth_op_e            op,
  input  logic                 shift,
  input  logic [WIDTH:0]       m_in,
  input  logic [WIDTH:0]       q_in,
  output logic [1:0]           booth_bits_c,
  output logic [2*WIDTH-1:0]   shift_prod_c
);

  localparam int unsigned N = WIDTH + 1;

  logic [N-1:0] m_q;
  logic [N-1:0] a_q;
  logic [N-1:0] q_q;
  logic         qp_q;
  logic [N-1:0] a_arith;

  // Modulo-2^N accumulate step selected by the Booth op.
  always_comb begin
    a_arith = a_q;
    case (op)
      ADD:     a_arith = a_q + m_q;
      SUB:     a_arith = a_q - m_q;
      default: a_arith = a_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q  <= '0;
      a_q  <= '0;
      q_q  <= '0;
      qp_q <= 1'b0;
    end else if (load) begin
      m_q  <= m_in;
      a_q  <= '0;
      q_q  <= q_in;
      qp_q <= 1'b0;
    end else if (shift) begin
      a_q  <= {a_q[N-1], a_q[N-1:1]};
      q_q  <= {a_q[0], q_q[N-1:1]};
      qp_q <= q_q[0];
    end else if (op != NOP) begin
      a_q  <= a_arith;
    end
  end

  assign booth_bits_c = {q_q[0], qp_q};
  // Low 2*WIDTH bits of {A,Q} as they will be after this cycle's shift.
  assign shift_prod_c = {a_q[WIDTH-1:0], q_q[WIDTH:1]};

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes and fixed
// 2*(WIDTH+1)-cycle latency. Optional abort input enabled by BOOTH_ABORT_EN.
module booth_multiplier_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef BOOTH_ABORT_EN
  input  logic                 abort_i,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 signed_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned N     = WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  booth_state_e         state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [PW-1:0]        prod_d;
  logic                 load;
  logic                 do_shift;
  booth_op_e            do_op;
  logic [N-1:0]         a_ext, b_ext;
  logic [1:0]           booth_bits_c;
  logic [PW-1:0]        shift_prod_c;
  logic                 abort_c;

  assign a_ext = signed_i ? {a_i[WIDTH-1], a_i} : {1'b0, a_i};
  assign b_ext = signed_i ? {b_i[WIDTH-1], b_i} : {1'b0, b_i};

`ifdef BOOTH_ABORT_EN
  assign abort_c = abort_i;
`else
  assign abort_c = 1'b0;
`endif

  booth_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .op           (do_op),
    .shift        (do_shift),
    .m_in         (a_ext),
    .q_in         (b_ext),
    .booth_bits_c (booth_bits_c),
    .shift_prod_c (shift_prod_c)
  );

  // Next-state, strobe and next-output logic.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    prod_d   = product_o;
    load     = 1'b0;
    do_op    = NOP;
    do_shift = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = OP;
        end
      end
      OP: begin
        do_op   = booth_op(booth_bits_c);
        state_d = SHIFT;
      end
      SHIFT: begin
        do_shift = 1'b1;
        cnt_d    = cnt + CNT_W'(1);
        if (cnt_d == CNT_W'(N)) begin
          state_d = DONE;
          prod_d  = shift_prod_c;
        end else begin
          state_d = OP;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort only bites while an operation is in flight.
    if (abort_c && (state == OP || state == SHIFT)) begin
      state_d  = IDLE;
      cnt_d    = '0;
      prod_d   = product_o;
      do_op    = NOP;
      do_shift = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      product_o <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      product_o <= prod_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq against an arithmetic reference model.
module tb_booth_multiplier_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a_i = '0;
  logic [7:0]  b_i = '0;
  logic        signed_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product_o;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [15:0] w_a = '0;
  logic [15:0] w_b = '0;
  logic        w_signed = 1'b0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b0;
  logic [31:0] w_product;

`ifdef BOOTH_ABORT_EN
  logic abort_i = 1'b0;
  logic w_abort = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [15:0] last_prod = '0;

  always #5 clk = ~clk;

  booth_multiplier_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef BOOTH_ABORT_EN
    .abort_i   (abort_i),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .signed_i  (signed_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product_o (product_o)
  );

  booth_multiplier_seq #(.WIDTH(16)) dut_w (
    .clk       (clk),
    .reset     (reset),
`ifdef BOOTH_ABORT_EN
    .abort_i   (w_abort),
`endif
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .a_i       (w_a),
    .b_i       (w_b),
    .signed_i  (w_signed),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .product_o (w_product)
  );

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input bit s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 16'(x * y);
  endfunction

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input bit s);
    @(negedge clk);
    a_i = a; b_i = b; signed_i = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid; returns 999 on timeout.
  task automatic wait_result(output int lat, output logic [15:0] p);
    lat = 999;
    p = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        p = product_o;
        break;
      end
    end
  endtask

  task automatic accept;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product_o !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b product=%h required 1 0 0000", in_ready, out_valid, product_o);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [7:0] av [4] = '{8'd3, 8'h80, 8'hFF, 8'h00};
    logic [7:0] bv [4] = '{8'hFC, 8'h80, 8'hFF, 8'h5A};
    bit         sv [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] ev [4] = '{16'hFFF4, 16'h4000, 16'hFE01, 16'h0000};
    int lat;
    logic [15:0] p;
    for (int i = 0; i < 4; i++) begin
      start_op(av[i], bv[i], sv[i]);
      wait_result(lat, p);
      checks++;
      if (p !== ev[i] || p !== model(av[i], bv[i], sv[i])) begin
        failures++;
        $display("FAIL directed_%0d product: got %h required %h", i, p, ev[i]);
      end
      checks++;
      if (lat != 18) begin
        failures++;
        $display("FAIL directed_%0d latency: got %0d required 18", i, lat);
      end
      last_prod = ev[i];
      accept();
    end
  endtask

  task automatic test_random;
    int lat;
    logic [15:0] p, e;
    logic [7:0] a, b;
    bit s;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      e = model(a, b, s);
      start_op(a, b, s);
      wait_result(lat, p);
      checks++;
      if (p !== e || lat != 18) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h s=%b: product %h lat %0d required %h lat 18", i, a, b, s, p, lat, e);
      end
      last_prod = e;
      accept();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [15:0] p, e;
    e = model(8'd100, 8'hF6, 1'b1);
    start_op(8'd100, 8'hF6, 1'b1);
    wait_result(lat, p);
    for (int k = 0; k < 10; k++) begin
      in_valid = (k == 3);
      a_i = 8'd1; b_i = 8'd1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || product_o !== e || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_%0d: out_valid=%b product=%h in_ready=%b required 1 %h 0", k, out_valid, product_o, in_ready, e);
      end
    end
    in_valid = 1'b0;
    accept();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product_o !== e) begin
      failures++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b product=%h required 1 0 %h", in_ready, out_valid, product_o, e);
    end
    last_prod = e;
  endtask

  task automatic test_ignore_busy;
    int lat;
    logic [15:0] p, e;
    e = model(8'd25, 8'd9, 1'b0);
    start_op(8'd25, 8'd9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a_i = 8'd200; b_i = 8'd77; signed_i = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat, p);
    checks++;
    if (p !== e || lat != 15) begin
      failures++;
      $display("FAIL ignore_busy: product %h lat %0d required %h lat 15", p, lat, e);
    end
    accept();
    last_prod = e;
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [15:0] p;
    start_op(8'd55, 8'd66, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || product_o !== 16'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: out_valid=%b product=%h in_ready=%b required 0 0000 1 (prev %h)", out_valid, product_o, in_ready, last_prod);
    end
    @(negedge clk);
    reset = 1'b1;
    start_op(8'd7, 8'd6, 1'b1);
    wait_result(lat, p);
    checks++;
    if (p !== 16'h002A || lat != 18) begin
      failures++;
      $display("FAIL after_reset: product %h lat %0d required 002a lat 18", p, lat);
    end
    accept();
    last_prod = 16'h002A;
  endtask

  task automatic test_wide;
    int lat;
    lat = 999;
    @(negedge clk);
    w_a = 16'd300; w_b = 16'hFFFB; w_signed = 1'b1; w_in_valid = 1'b1;
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (w_out_valid) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (w_product !== 32'hFFFFFA24 || lat != 34) begin
      failures++;
      $display("FAIL wide16: product %h lat %0d required fffffa24 lat 34", w_product, lat);
    end
    @(negedge clk);
    w_out_ready = 1'b1;
    @(posedge clk);
    #1 w_out_ready = 1'b0;
  endtask

`ifdef BOOTH_ABORT_EN
  task automatic test_abort;
    int lat;
    logic [15:0] p;
    start_op(8'd11, 8'd13, 1'b0);
    repeat (5) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product_o !== last_prod) begin
      failures++;
      $display("FAIL abort: in_ready=%b out_valid=%b product=%h required 1 0 %h", in_ready, out_valid, product_o, last_prod);
    end
    repeat (25) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_valid: out_valid=%b required 0", out_valid);
      end
    end
    start_op(8'd11, 8'd13, 1'b0);
    wait_result(lat, p);
    checks++;
    if (p !== 16'd143 || lat != 18) begin
      failures++;
      $display("FAIL after_abort: product %h lat %0d required 008f lat 18", p, lat);
    end
    accept();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid();
    test_wide();
`ifdef BOOTH_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
